pipeline_hazard_ctrl: RTL and testbench

Parametrised stall, flush and multi-cycle scoreboard controller for the 5-stage MIPS pipeline, sitting in the ID stage next to the main decoder. It supersedes the combinational load-use/branch hazard logic. It adds:
- a clean priority between branch flush and stalls;
- register-0 exclusion;
- a tracked multi-cycle functional unit (mult/div class) with a configurable latency, RAW/structural interlocks and wrong-path cancellation.

---
 rtl/pipeline_hazard_ctrl_if.sv | 35 +++
 rtl/pipeline_hazard_ctrl.sv | 109 ++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control signal bundle between the ID-stage pipeline (master) and
// pipeline_hazard_ctrl (slave).
interface pipeline_hazard_ctrl_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] ifid_rs;
  logic [REG_AW-1:0] ifid_rt;
  logic              ifid_mc_start;
  logic [REG_AW-1:0] ifid_mc_dst;
  logic              idex_memread;
  logic [REG_AW-1:0] idex_rt;
  logic              pcsrc;
  logic              pc_write;
  logic              ifid_write;
  logic              bubble_idex;
  logic              flush_ifid;
  logic              flush_exmem;
  logic              mc_busy;
  logic              mc_done;
  logic [REG_AW-1:0] mc_dst;

  modport master (
    output ifid_rs, ifid_rt, ifid_mc_start, ifid_mc_dst,
           idex_memread, idex_rt, pcsrc,
    input  pc_write, ifid_write, bubble_idex, flush_ifid, flush_exmem,
           mc_busy, mc_done, mc_dst
  );

  modport slave (
    input  ifid_rs, ifid_rt, ifid_mc_start, ifid_mc_dst,
           idex_memread, idex_rt, pcsrc,
    output pc_write, ifid_write, bubble_idex, flush_ifid, flush_exmem,
           mc_busy, mc_done, mc_dst
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// ID-stage stall/flush controller with an optional multi-cycle unit scoreboard.
// Define HAZARD_MC_EN to enable the multi-cycle tracking; otherwise load-use + flush only.
//
//   state | meaning
//   IDLE  | multi-cycle unit free, may accept an op from ID
//   RUN   | op in flight, cnt counts 1..MC_LAT
module pipeline_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 4
) (
  input logic                  clock,
  input logic                  reset,
  pipeline_hazard_ctrl_if.slave hz
);

  logic load_use;
  logic stall;

  assign load_use = hz.idex_memread && (hz.idex_rt != '0) &&
                    ((hz.idex_rt == hz.ifid_rs) || (hz.idex_rt == hz.ifid_rt));

`ifdef HAZARD_MC_EN
  typedef enum logic {IDLE, RUN} state_t;

  localparam int CW = $clog2(MC_LAT + 1);
  localparam logic [CW-1:0] LAT_C = CW'(MC_LAT);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [REG_AW-1:0] dst_q, dst_d;
  logic              run;
  logic              mc_raw;
  logic              mc_struct;
  logic              accept;
  logic              cancel;
  logic              done;

  assign run       = (state_q == RUN);
  assign mc_raw    = run && (dst_q != '0) &&
                     ((dst_q == hz.ifid_rs) || (dst_q == hz.ifid_rt) ||
                      (hz.ifid_mc_start && (dst_q == hz.ifid_mc_dst)));
  assign mc_struct = run && hz.ifid_mc_start;
  assign stall     = (load_use || mc_raw || mc_struct) && !hz.pcsrc;
  assign accept    = !run && hz.ifid_mc_start && !stall && !hz.pcsrc;
  // On the first RUN cycle the resolving branch is older than the op.
  assign cancel    = run && hz.pcsrc && (cnt_q == ONE_C);
  assign done      = run && (cnt_q == LAT_C) && !cancel;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dst_d   = dst_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          cnt_d   = ONE_C;
          dst_d   = hz.ifid_mc_dst;
        end
      end
      RUN: begin
        if (cancel || (cnt_q == LAT_C)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dst_q   <= dst_d;
    end
  end

  assign hz.mc_busy = run;
  assign hz.mc_done = done;
  assign hz.mc_dst  = dst_q;
`else
  logic unused_mc;

  assign unused_mc  = ^{clock, reset, hz.ifid_mc_start, hz.ifid_mc_dst};
  assign stall      = load_use && !hz.pcsrc;
  assign hz.mc_busy = 1'b0;
  assign hz.mc_done = 1'b0;
  assign hz.mc_dst  = '0;
`endif

  // A taken branch overrides any stall: everything younger is squashed.
  assign hz.pc_write    = hz.pcsrc || !stall;
  assign hz.ifid_write  = hz.pcsrc || !stall;
  assign hz.bubble_idex = hz.pcsrc || stall;
  assign hz.flush_ifid  = hz.pcsrc;
  assign hz.flush_exmem = hz.pcsrc;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed vectors, corner sequences,
// and random stimulus against a cycle-timeline reference model.
module tb_pipeline_hazard_ctrl;
  localparam int REG_AW = 5;
  localparam int MC_LAT = 4;
`ifdef HAZARD_MC_EN
  localparam bit MC_EN = 1'b1;
`else
  localparam bit MC_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  pipeline_hazard_ctrl_if #(.REG_AW(REG_AW)) hz ();

  pipeline_hazard_ctrl #(.REG_AW(REG_AW), .MC_LAT(MC_LAT)) dut (
    .clock (clock),
    .reset (reset),
    .hz    (hz)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the op accepted at cycle t_acc occupies the unit in
  // cycles t_acc+1 .. t_acc+MC_LAT and completes in the last of them.
  int          cyc = 0;
  int          t_acc = 0;
  bit          t_acc_v = 1'b0;
  logic [4:0]  m_dst = '0;

  logic last_pcw, last_busy, last_done;

  typedef struct {
    logic       mr;
    logic [4:0] irt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       pc;
    logic [4:0] exp_o;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic drive(input logic mr, input logic [4:0] irt, input logic [4:0] rs,
                       input logic [4:0] rt, input logic ms, input logic [4:0] md,
                       input logic pc);
    hz.idex_memread  = mr;
    hz.idex_rt       = irt;
    hz.ifid_rs       = rs;
    hz.ifid_rt       = rt;
    hz.ifid_mc_start = ms;
    hz.ifid_mc_dst   = md;
    hz.pcsrc         = pc;
  endtask

  function automatic logic [4:0] outs();
    return {hz.pc_write, hz.ifid_write, hz.bubble_idex, hz.flush_ifid, hz.flush_exmem};
  endfunction

  // Called just after a negedge with inputs applied; checks, then clocks the model.
  task automatic step(input string nm);
    bit bm, dm, lu, raw, stc, stl;
    logic [4:0] expv;
    #1;
    bm  = MC_EN && t_acc_v && (cyc > t_acc) && (cyc <= t_acc + MC_LAT);
    dm  = bm && (cyc == t_acc + MC_LAT);
    lu  = hz.idex_memread && (hz.idex_rt != 0) &&
          (hz.idex_rt == hz.ifid_rs || hz.idex_rt == hz.ifid_rt);
    raw = bm && (m_dst != 0) && (m_dst == hz.ifid_rs || m_dst == hz.ifid_rt ||
          (hz.ifid_mc_start && m_dst == hz.ifid_mc_dst));
    stc = bm && hz.ifid_mc_start;
    stl = (lu || raw || stc) && !hz.pcsrc;
    expv = hz.pcsrc ? 5'b11111 : {!stl, !stl, stl, 2'b00};
    chk({nm, ".outs"}, outs(), expv);
    chk({nm, ".busy"}, hz.mc_busy, bm);
    chk({nm, ".done"}, hz.mc_done, dm);
    if (bm) chk({nm, ".dst"}, hz.mc_dst, m_dst);
    last_pcw  = hz.pc_write;
    last_busy = hz.mc_busy;
    last_done = hz.mc_done;
    if (bm && hz.pcsrc && cyc == t_acc + 1) t_acc_v = 1'b0;
    else if (MC_EN && !bm && hz.ifid_mc_start && !stl && !hz.pcsrc) begin
      t_acc   = cyc;
      t_acc_v = 1'b1;
      m_dst   = hz.ifid_mc_dst;
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  initial begin
    vec_t vecs[8];
    int   stalls, done_idx, dones, busies;

    vecs[0] = '{1'b1, 5'd5,  5'd5,  5'd0, 1'b0, 5'b00100};
    vecs[1] = '{1'b1, 5'd0,  5'd0,  5'd0, 1'b0, 5'b11000};
    vecs[2] = '{1'b1, 5'd5,  5'd3,  5'd5, 1'b0, 5'b00100};
    vecs[3] = '{1'b0, 5'd5,  5'd5,  5'd0, 1'b0, 5'b11000};
    vecs[4] = '{1'b1, 5'd5,  5'd5,  5'd0, 1'b1, 5'b11111};
    vecs[5] = '{1'b0, 5'd0,  5'd0,  5'd0, 1'b1, 5'b11111};
    vecs[6] = '{1'b1, 5'd7,  5'd6,  5'd8, 1'b0, 5'b11000};
    vecs[7] = '{1'b1, 5'd31, 5'd31, 5'd0, 1'b0, 5'b00100};

    idle();
    #3;
    chk("rst.outs", outs(), 5'b11000);
    chk("rst.busy", hz.mc_busy, 1'b0);
    chk("rst.done", hz.mc_done, 1'b0);
    chk("rst.dst",  hz.mc_dst, 5'd0);
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].mr, vecs[i].irt, vecs[i].rs, vecs[i].rt, 1'b0, 5'd0, vecs[i].pc);
      #1;
      chk($sformatf("vec%0d", i), outs(), vecs[i].exp_o);
      @(negedge clock);
    end

    // RAW on a multi-cycle destination
    idle(); hz.ifid_mc_start = 1'b1; hz.ifid_mc_dst = 5'd8;
    step("raw.acc");
    idle(); hz.ifid_rs = 5'd8;
    stalls = 0; done_idx = 0;
    for (int i = 0; i < 20; i++) begin
      step("raw.wait");
      if (last_pcw) break;
      stalls++;
      if (last_done) done_idx = stalls;
    end
    chk("raw.stalls", stalls, MC_EN ? MC_LAT : 0);
    chk("raw.done_at", done_idx, MC_EN ? MC_LAT : 0);

    // Structural back-to-back
    idle(); hz.ifid_mc_start = 1'b1; hz.ifid_mc_dst = 5'd9;
    step("str.acc1");
    hz.ifid_mc_dst = 5'd10;
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      step("str.wait");
      if (last_pcw) break;
      stalls++;
    end
    chk("str.stalls", stalls, MC_EN ? MC_LAT : 0);
    idle();
    step("str.nogap");
    chk("str.busy_after", last_busy, MC_EN);
    for (int i = 0; i < MC_LAT + 1; i++) step("str.drain");

    // Cancellation by an older branch
    idle(); hz.ifid_mc_start = 1'b1; hz.ifid_mc_dst = 5'd11;
    step("cnl.acc");
    idle(); hz.pcsrc = 1'b1;
    step("cnl.br");
    idle();
    dones = 0; busies = 0;
    for (int i = 0; i < MC_LAT + 2; i++) begin
      step("cnl.after");
      dones  += int'(last_done);
      busies += int'(last_busy);
    end
    chk("cnl.dones", dones, 0);
    chk("cnl.busies", busies, 0);

    // Younger branch at cnt=3 does not cancel
    idle(); hz.ifid_mc_start = 1'b1; hz.ifid_mc_dst = 5'd12;
    step("ybr.acc");
    idle();
    step("ybr.c1");
    step("ybr.c2");
    hz.pcsrc = 1'b1;
    step("ybr.c3");
    idle();
    dones = 0;
    for (int i = 0; i < MC_LAT; i++) begin
      step("ybr.after");
      dones += int'(last_done);
    end
    chk("ybr.dones", dones, MC_EN ? 1 : 0);

    // Asynchronous reset mid-RUN (cnt=2)
    idle(); hz.ifid_mc_start = 1'b1; hz.ifid_mc_dst = 5'd13;
    step("ars.acc");
    idle();
    step("ars.c1");
    #1 reset = 1'b1;
    #1;
    chk("ars.busy", hz.mc_busy, 1'b0);
    chk("ars.done", hz.mc_done, 1'b0);
    chk("ars.dst",  hz.mc_dst, 5'd0);
    chk("ars.outs", outs(), 5'b11000);
    #1 reset = 1'b0;
    t_acc_v = 1'b0;
    m_dst   = '0;
    dones = 0; busies = 0;
    for (int i = 0; i < MC_LAT + 2; i++) begin
      step("ars.after");
      dones  += int'(last_done);
      busies += int'(last_busy);
    end
    chk("ars.dones", dones, 0);
    chk("ars.busies", busies, 0);

    // Random traffic over a small register set to provoke collisions
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 1) == 1),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
            5'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
      step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
